alu_iter: RTL and testbench

//   Multi-cycle ALU responder behind a valid/ready request/response interface.
//   It accepts one {A, B, ALUOp} request at a time and performs add/sub/and/or
//   in one cycle. It performs srl/sra iteratively, one bit per cycle.
//   It serves as the sequential execution back end for the P1 ALU op set,

---
 rtl/alu_iter.sv | 81 ++++++++
 tb/tb_alu_iter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: valid/ready ALU responder, single-cycle add/sub/and/or, bit-serial srl/sra
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q, c_q, alu_d, shr_d;
  logic [CW-1:0]    cnt_q, n_d;
  logic             out_valid_q;
  // single-cycle result, saturated shift count (any B bit at or above WIDTH saturates), one-bit shift step
  always_comb begin
    alu_d = ALUOp == 3'd0 ? A + B :
            ALUOp == 3'd1 ? A - B :
            ALUOp == 3'd2 ? A & B :
            ALUOp == 3'd3 ? A | B : '0;
    n_d   = |B[WIDTH-1:CW-1] ? CW'(WIDTH) : {1'b0, B[CW-2:0]};
    shr_d = {op_q == 3'd5 ? acc_q[WIDTH-1] : 1'b0, acc_q[WIDTH-1:1]};
  end
  // request/shift/response FSM; C and out_valid are registered and held until the handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= ALUOp;
          if (ALUOp[2:1] == 2'b10) begin
            acc_q <= A;
            cnt_q <= n_d;
            if (n_d == '0) begin
              c_q         <= A;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= SHIFT;
            end
          end else begin
            c_q         <= alu_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        SHIFT: begin
          acc_q <= shr_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            c_q         <= shr_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign C         = c_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed vectors into a scoreboard checked by an independent response monitor
module tb_alu_iter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  ALUOp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] C;

  typedef struct {
    logic [31:0] c;
    int          acc;
    int          d;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  bit   seen = 1'b0;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready), .C(C)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // d = clock edges after the accepting edge before out_valid is first seen high
  task automatic req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                     input logic [31:0] c, input int d);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL req_timeout: in_ready stuck low, expected high");
    end else begin
      A = a;
      B = b;
      ALUOp = op;
      in_valid = 1'b1;
      sb.push_back('{c, cyc + 1, d});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
      ALUOp = 3'($urandom);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: %0d responses pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // response monitor: latency on first sight of out_valid, result on the handshake
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL spurious_valid: out_valid=1 C=%h, expected no response", C);
        end else begin
          check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].d));
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        check("result", C, sb[0].c);
        void'(sb.pop_front());
        seen = 1'b0;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_C", C, 32'd0);
    reset = 1'b0;
    req(32'd100, 32'd99, 3'd0, 32'd199, 0);
    req(32'd100, 32'd99, 3'd1, 32'd1, 0);
    req(32'h00ff00ff, 32'hff00ff00, 3'd2, 32'h0, 0);
    req(32'h00ff00ff, 32'hff00ff00, 3'd3, 32'hffffffff, 0);
    req(32'hffffffff, 32'd2, 3'd0, 32'd1, 0);
    req(32'd0, 32'd1, 3'd1, 32'hffffffff, 0);
    req(32'h0fffffff, 32'd12, 3'd4, 32'h0000ffff, 12);
    req(32'hffffffff, 32'd32, 3'd4, 32'h0, 32);
    req(32'h80000000, 32'd31, 3'd4, 32'h1, 31);
    req(32'h12345678, 32'h100, 3'd4, 32'h0, 32);
    req(32'hefffffff, 32'd12, 3'd5, 32'hfffeffff, 12);
    req(32'h3fffffff, 32'd12, 3'd5, 32'h0003ffff, 12);
    req(32'hffffffff, 32'd32, 3'd5, 32'hffffffff, 32);
    req(32'h3fffffff, 32'd32, 3'd5, 32'h0, 32);
    req(32'h80000000, 32'd33, 3'd5, 32'hffffffff, 32);
    req(32'h80001234, 32'd0, 3'd5, 32'h80001234, 0);
    req(32'h5a5a5a5a, 32'd0, 3'd4, 32'h5a5a5a5a, 0);
    req(32'h12345678, 32'h1, 3'd6, 32'h0, 0);
    req(32'h12345678, 32'h1, 3'd7, 32'h0, 0);
    drain();
    out_ready = 1'b0;
    req(32'd5, 32'd6, 3'd0, 32'd11, 0);
    A = 32'd7;
    B = 32'd1;
    ALUOp = 3'd0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_C", C, 32'd11);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    req(32'd7, 32'd1, 3'd0, 32'd8, 0);
    drain();
    req(32'habcdef01, 32'd20, 3'd4, 32'h0, 20);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_C", C, 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
    end
    req(32'd2, 32'd3, 3'd0, 32'd5, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
